// File: rtl/coax_buffer_drain_pkg.sv
// Shared coax constants: word width, drain FSM encoding, default ready timeout.
package coax_buffer_drain_pkg;

  localparam int COAX_WORD_W               = 10;
  localparam int COAX_READY_TIMEOUT_DEFAULT = 65535;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READ   = 3'd1,
    ST_LATCH  = 3'd2,
    ST_OFFER  = 3'd3,
    ST_FLUSH  = 3'd4,
    ST_FINISH = 3'd5
  } drain_state_t;

endpackage

// File: rtl/coax_buffer_drain_timeout.sv
// Saturating cycle counter; o_expired flags the last enabled cycle before LIMIT is reached.
module coax_timeout_counter #(
  parameter int WIDTH = 16,
  parameter int LIMIT = 65535
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam logic [WIDTH-1:0] TERM = WIDTH'(LIMIT - 1);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset || i_clear)
      r_count <= '0;
    else if (i_enable && (r_count != TERM))
      r_count <= r_count + 1'b1;
  end

  // The cycle that would bring the count to LIMIT is the expiring one.
  assign o_expired = i_enable && (r_count == TERM);

endmodule

// File: rtl/coax_buffer_drain.sv
// Drains the coax transmit buffer into the transmitter, one word per tx_ready handshake.
//   state  | meaning
//   IDLE   | waiting for start
//   READ   | pop strobe to buffer
//   LATCH  | capture head word into tx_data
//   OFFER  | present word, wait tx_ready (with timeout)
//   FLUSH  | wait for transmitter to go idle
//   FINISH | done pulse
module coax_buffer_drain
  import coax_buffer_drain_pkg::*;
#(
  parameter int COUNT_WIDTH   = 10,
  parameter int READY_TIMEOUT = COAX_READY_TIMEOUT_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [COAX_WORD_W-1:0] buffer_read_data,
  input  logic                   buffer_empty,
  output logic                   buffer_read_strobe,
  output logic [COAX_WORD_W-1:0] tx_data,
  output logic                   tx_load,
  input  logic                   tx_ready,
  input  logic                   tx_active,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [COUNT_WIDTH-1:0] word_count
);

  localparam int TO_W = (READY_TIMEOUT > 1) ? $clog2(READY_TIMEOUT) : 1;

  drain_state_t            r_state;
  drain_state_t            w_next;
  logic [COAX_WORD_W-1:0]  r_tx_data;
  logic [COUNT_WIDTH-1:0]  r_word_count;
  logic                    r_error;
  logic                    r_done;
  logic                    w_expired;
  logic                    w_start_ok;
  logic                    w_start_empty;

  assign w_start_ok    = (r_state == ST_IDLE) && start && !buffer_empty;
  assign w_start_empty = (r_state == ST_IDLE) && start && buffer_empty;

  coax_timeout_counter #(
    .WIDTH (TO_W),
    .LIMIT (READY_TIMEOUT)
  ) u_timeout (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (r_state == ST_LATCH),
    .i_enable  ((r_state == ST_OFFER) && !tx_ready),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (reset)
      r_state <= ST_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_start_ok) w_next = ST_READ;
      ST_READ:   w_next = ST_LATCH;
      ST_LATCH:  w_next = ST_OFFER;
      ST_OFFER: begin
        if (tx_ready)
          w_next = buffer_empty ? ST_FLUSH : ST_READ;
        else if (w_expired)
          w_next = ST_FINISH;
      end
      ST_FLUSH:  if (tx_ready && !tx_active) w_next = ST_FINISH;
      ST_FINISH: w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    buffer_read_strobe = (r_state == ST_READ);
    tx_load            = (r_state == ST_OFFER) && tx_ready;
    busy               = (r_state != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_data    <= '0;
      r_word_count <= '0;
      r_error      <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= (w_next == ST_FINISH) || w_start_empty;
      if (r_state == ST_LATCH)
        r_tx_data <= buffer_read_data;
      if ((r_state == ST_IDLE) && start) begin
        r_word_count <= '0;
        r_error      <= buffer_empty;
      end else if ((r_state == ST_OFFER) && !tx_ready && w_expired) begin
        r_error <= 1'b1;
      end else if (tx_load && (r_word_count != '1)) begin
        r_word_count <= r_word_count + 1'b1;
      end
    end
  end

  assign tx_data    = r_tx_data;
  assign word_count = r_word_count;
  assign error      = r_error;
  assign done       = r_done;

endmodule

// File: tb/tb_coax_buffer_drain.sv
// Directed bench for coax_buffer_drain with a queue-style buffer and a simple transmitter model.
module tb_coax_buffer_drain;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [9:0] buffer_read_data = '0;
  logic       buffer_empty;
  logic       buffer_read_strobe;
  logic [9:0] tx_data;
  logic       tx_load;
  logic       tx_ready = 1'b1;
  logic       tx_active = 1'b0;
  logic       busy, done, error;
  logic [9:0] word_count;

  always #5 clk = ~clk;

  coax_buffer_drain #(
    .COUNT_WIDTH   (10),
    .READY_TIMEOUT (8)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .start              (start),
    .buffer_read_data   (buffer_read_data),
    .buffer_empty       (buffer_empty),
    .buffer_read_strobe (buffer_read_strobe),
    .tx_data            (tx_data),
    .tx_load            (tx_load),
    .tx_ready           (tx_ready),
    .tx_active          (tx_active),
    .busy               (busy),
    .done               (done),
    .error              (error),
    .word_count         (word_count)
  );

  // Buffer model: head word appears the cycle after the pop strobe.
  logic [9:0] mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign buffer_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (buffer_read_strobe) begin
      buffer_read_data <= mem[rd_ptr[5:0]];
      rd_ptr <= rd_ptr + 1;
    end
  end

  // Transmitter model: ready returns 4 cycles after a load, line idles 7 cycles after.
  logic tx_hold = 1'b0;
  int rdy_cnt = 0;
  int act_cnt = 0;

  always @(posedge clk) begin
    if (tx_hold) begin
      tx_ready <= 1'b0; tx_active <= 1'b0; rdy_cnt <= 0; act_cnt <= 0;
    end else if (tx_load) begin
      tx_ready <= 1'b0; tx_active <= 1'b1; rdy_cnt <= 4; act_cnt <= 7;
    end else begin
      if (rdy_cnt > 1) rdy_cnt <= rdy_cnt - 1;
      else begin rdy_cnt <= 0; tx_ready <= 1'b1; end
      if (act_cnt > 1) act_cnt <= act_cnt - 1;
      else begin act_cnt <= 0; tx_active <= 1'b0; end
    end
  end

  // Monitor
  int strobe_n = 0, load_n = 0, done_n = 0, cyc = 0, strobe_cyc = 0, done_cyc = 0;
  logic done_act = 1'b0;
  logic [9:0] log_w [0:63];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (buffer_read_strobe) begin strobe_n <= strobe_n + 1; strobe_cyc <= cyc; end
    if (tx_load) begin log_w[load_n[5:0]] <= tx_data; load_n <= load_n + 1; end
    if (done) begin done_n <= done_n + 1; done_cyc <= cyc; done_act <= tx_active; end
  end

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [9:0] w);
    mem[wr_ptr[5:0]] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int d0, input int budget);
    for (int k = 0; k < budget && done_n == d0; k++) @(negedge clk);
    check(tag, int'(done_n != d0), 1);
  endtask

  int s0, l0, d0;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_strobe", buffer_read_strobe, 0);
    check("rst_load", tx_load, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_count", word_count, 0);

    // 1: full 16-word drain
    for (int i = 0; i < 16; i++) push(10'(i));
    s0 = strobe_n; l0 = load_n; d0 = done_n;
    pulse_start();
    wait_done("t1_done_seen", d0, 600);
    repeat (3) @(negedge clk);
    check("t1_loads", load_n - l0, 16);
    check("t1_strobes", strobe_n - s0, 16);
    for (int i = 0; i < 16; i++) check($sformatf("t1_word%0d", i), log_w[l0 + i], i);
    check("t1_count", word_count, 16);
    check("t1_done_once", done_n - d0, 1);
    check("t1_done_after_idle", done_act, 0);
    check("t1_error", error, 0);
    check("t1_busy", busy, 0);

    // 2: start with empty buffer
    s0 = strobe_n; l0 = load_n; d0 = done_n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t2_done", done, 1);
    check("t2_error", error, 1);
    check("t2_busy", busy, 0);
    @(negedge clk);
    check("t2_done_pulse", done, 0);
    check("t2_count", word_count, 0);
    check("t2_strobes", strobe_n - s0, 0);
    check("t2_loads", load_n - l0, 0);
    check("t2_busy_after", busy, 0);

    // 3: tx_ready timeout
    tx_hold = 1'b1;
    @(negedge clk);
    push(10'h031); push(10'h032); push(10'h033);
    s0 = strobe_n; l0 = load_n; d0 = done_n;
    pulse_start();
    wait_done("t3_done_seen", d0, 100);
    check("t3_strobes", strobe_n - s0, 1);
    check("t3_loads", load_n - l0, 0);
    check("t3_timeout_cycles", done_cyc - strobe_cyc, 10);
    check("t3_error", error, 1);
    check("t3_left_in_buffer", wr_ptr - rd_ptr, 2);
    tx_hold = 1'b0;
    wr_ptr = rd_ptr;
    repeat (3) @(negedge clk);

    // 4: word pushed mid-drain is included
    push(10'h011); push(10'h022);
    s0 = strobe_n; l0 = load_n; d0 = done_n;
    pulse_start();
    @(negedge clk);
    push(10'h3FF);
    wait_done("t4_done_seen", d0, 200);
    check("t4_loads", load_n - l0, 3);
    check("t4_word0", log_w[l0], 10'h011);
    check("t4_word1", log_w[l0 + 1], 10'h022);
    check("t4_word2", log_w[l0 + 2], 10'h3FF);
    check("t4_count", word_count, 3);
    check("t4_error_cleared", error, 0);
    repeat (3) @(negedge clk);

    // 5: reset while in OFFER, then fresh drain
    push(10'h101); push(10'h102); push(10'h103); push(10'h104);
    l0 = load_n;
    pulse_start();
    for (int k = 0; k < 50 && load_n == l0; k++) @(negedge clk);
    check("t5_first_load", load_n - l0, 1);
    @(negedge clk);
    @(negedge clk);
    check("t5_busy_before_reset", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    check("t5_rst_strobe", buffer_read_strobe, 0);
    check("t5_rst_load", tx_load, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_done", done, 0);
    check("t5_rst_error", error, 0);
    check("t5_rst_tx_data", tx_data, 0);
    check("t5_rst_count", word_count, 0);
    reset = 1'b0;
    check("t5_left_in_buffer", wr_ptr - rd_ptr, 2);
    s0 = strobe_n; l0 = load_n; d0 = done_n;
    pulse_start();
    wait_done("t5_done_seen", d0, 200);
    check("t5_loads", load_n - l0, 2);
    check("t5_word0", log_w[l0], 10'h103);
    check("t5_word1", log_w[l0 + 1], 10'h104);
    check("t5_count", word_count, 2);
    repeat (3) @(negedge clk);

    // 6: start while busy is ignored
    push(10'h201); push(10'h202); push(10'h203); push(10'h204);
    s0 = strobe_n; l0 = load_n; d0 = done_n;
    pulse_start();
    repeat (4) @(negedge clk);
    pulse_start();
    wait_done("t6_done_seen", d0, 300);
    repeat (10) @(negedge clk);
    check("t6_done_once", done_n - d0, 1);
    check("t6_strobes", strobe_n - s0, 4);
    check("t6_loads", load_n - l0, 4);
    check("t6_count", word_count, 4);
    check("t6_error", error, 0);
    check("t6_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
